// File: rtl/mem_access_stage.sv
// LEGv8 MEM stage: issues LDUR/STUR over a req/ack port and stalls upstream while busy.
// Define MEM_BYTE_OP_EN to add the ByteOp_d input for LDURB/STURB.
module mem_access_stage #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] alu_result_d,
    input  logic [63:0] store_data_d,
    input  logic [4:0]  reg_write_addr_d,
    input  logic        RegWrite_d,
    input  logic        MemRead_d,
    input  logic        MemWrite_d,
`ifdef MEM_BYTE_OP_EN
    input  logic        ByteOp_d,
`endif
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_be,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_reg_addr,
    output logic        wb_RegWrite,
    output logic        stall,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [63:0]       r_addr;
    logic [63:0]       r_wdata;
    logic [7:0]        r_be;
    logic [CNT_W-1:0]  r_cnt;
    logic [63:0]       r_rdata;
    logic              r_err;
    logic              r_timeout;

    logic              w_mem_op;
    logic              w_timeout;
    logic [7:0]        w_be;
    logic [63:0]       w_wdata;
    logic [63:0]       w_rdata;

    assign w_mem_op  = MemRead_d | MemWrite_d;
    assign w_timeout = (MAX_WAIT > 0) && (r_cnt == CNT_W'(MAX_WAIT));

`ifdef MEM_BYTE_OP_EN
    // Byte stores replicate the byte on every lane; byte loads zero-extend the addressed lane.
    assign w_be    = ByteOp_d ? (8'b1 << alu_result_d[2:0]) : 8'hFF;
    assign w_wdata = ByteOp_d ? {8{store_data_d[7:0]}} : store_data_d;
    assign w_rdata = ByteOp_d ? {56'b0, mem_rdata[{r_addr[2:0], 3'b000} +: 8]}
                              : mem_rdata;
`else
    assign w_be    = 8'hFF;
    assign w_wdata = store_data_d;
    assign w_rdata = mem_rdata;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_addr    <= alu_result_d;
                        r_wdata   <= w_wdata;
                        r_we      <= MemWrite_d;
                        r_be      <= w_be;
                        r_req     <= 1'b1;
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_rdata <= w_rdata;
                        end
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_cnt     <= '0;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_RESP;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wb_data     = alu_result_d;
        wb_reg_addr = reg_write_addr_d;
        wb_RegWrite = RegWrite_d;
        stall       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    stall       = 1'b1;
                    wb_RegWrite = 1'b0;
                end
            end
            S_REQ: begin
                stall       = 1'b1;
                wb_RegWrite = 1'b0;
            end
            S_RESP: begin
                if (!r_we) begin
                    wb_data = r_rdata;
                end
                wb_RegWrite = RegWrite_d & ~r_timeout;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign mem_err   = r_err;

endmodule
